// File: rtl/bn_seq_ctrl.sv
// bn_seq_ctrl -- sequencing controller for an external batch-norm datapath.
//
// Streams a frame of CHANNELS channels, each HEIGHT*WIDTH elements, towards
// a combinational BN datapath. Per channel it first accepts one parameter
// set (mean, variance, scale, bias), then streams that channel's elements.
// Two register stages surround the external datapath: stage 1 holds the
// packed operands, stage 2 captures the datapath result.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   start                        frame start pulse (honoured only in IDLE)
//   param_valid/param_ready      per-channel parameter handshake
//   param_mean/var/weight/bias   channel parameters
//   in_valid/in_ready/in_data    feature element stream
//   bn_data_1                    {pad, bias, weight, data} to datapath
//   bn_data_2                    {pad, var, mean} to datapath
//   bn_result                    combinational datapath result
//   out_valid/out_ready          result handshake
//   out_data/out_last            result and end-of-frame marker
//   busy, done, err_div0         status: active, frame-complete pulse,
//                                sticky zero-variance flag
module bn_seq_ctrl #(
  parameter int BITWIDTH     = 32,
  parameter int SECTOR_WIDTH = 8,
  parameter int HEIGHT       = 1,
  parameter int WIDTH        = 5,
  parameter int CHANNELS     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    param_valid,
  output logic                    param_ready,
  input  logic [SECTOR_WIDTH-1:0] param_mean,
  input  logic [SECTOR_WIDTH-1:0] param_var,
  input  logic [SECTOR_WIDTH-1:0] param_weight,
  input  logic [SECTOR_WIDTH-1:0] param_bias,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SECTOR_WIDTH-1:0] in_data,
  output logic [BITWIDTH-1:0]     bn_data_1,
  output logic [BITWIDTH-1:0]     bn_data_2,
  input  logic [BITWIDTH-1:0]     bn_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BITWIDTH-1:0]     out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done,
  output logic                    err_div0
);

  localparam int ELEMS = HEIGHT * WIDTH;
  localparam int EW    = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam logic [EW-1:0] ELEM_LAST = EW'(ELEMS - 1);
  localparam logic [CW-1:0] CH_LAST   = CW'(CHANNELS - 1);

  logic [1:0]              state;
  logic [EW-1:0]           elem_cnt;
  logic [CW-1:0]           ch_cnt;
  logic [SECTOR_WIDTH-1:0] mean_q, var_q, weight_q, bias_q;
  logic [SECTOR_WIDTH-1:0] var_safe;
  logic                    s1_valid, s1_last;
  logic                    advance, accept, param_hs;
  logic                    elem_last, ch_last;
  logic [BITWIDTH-1:0]     d1_next, d2_next;

  // Both pipeline stages move together; a stalled output freezes everything
  // behind it, so nothing can be overwritten or duplicated.
  assign advance     = !out_valid || out_ready;
  assign in_ready    = (state == RUN) && advance;
  assign param_ready = (state == LOAD);
  assign accept      = in_valid && in_ready;
  assign param_hs    = param_valid && param_ready;
  assign busy        = (state != IDLE);
  assign elem_last   = (elem_cnt == ELEM_LAST);
  assign ch_last     = (ch_cnt == CH_LAST);

  // A zero variance would make the datapath divide by zero; feed it 1 instead
  // and let err_div0 tell software the channel was degenerate.
  assign var_safe = (var_q == '0) ? SECTOR_WIDTH'(1) : var_q;

  // Operand packing for the datapath, zero-padded to the full word.
  always_comb begin
    d1_next = '0;
    d1_next[3*SECTOR_WIDTH-1:0] = {bias_q, weight_q, in_data};
    d2_next = '0;
    d2_next[2*SECTOR_WIDTH-1:0] = {var_safe, mean_q};
  end

  // Frame sequencing: one LOAD per channel, RUN streams that channel's
  // elements, DRAIN waits until the final result has left the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      elem_cnt <= '0;
      ch_cnt   <= '0;
      done     <= 1'b0;
      err_div0 <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            elem_cnt <= '0;
            ch_cnt   <= '0;
            err_div0 <= 1'b0;
          end
        end
        LOAD: begin
          if (param_hs) begin
            state <= RUN;
            if (param_var == '0) begin
              err_div0 <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            if (elem_last) begin
              elem_cnt <= '0;
              if (ch_last) begin
                state <= DRAIN;
              end else begin
                ch_cnt <= ch_cnt + 1'b1;
                state  <= LOAD;
              end
            end else begin
              elem_cnt <= elem_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          // The marked result is the last one in flight, so its acceptance
          // means the pipeline is empty.
          if (out_valid && out_ready && out_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Channel parameters, captured on the LOAD handshake and stable for the
  // whole RUN phase of that channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mean_q   <= '0;
      var_q    <= '0;
      weight_q <= '0;
      bias_q   <= '0;
    end else if (param_hs) begin
      mean_q   <= param_mean;
      var_q    <= param_var;
      weight_q <= param_weight;
      bias_q   <= param_bias;
    end
  end

  // Stage 1: operands are only rewritten on an accepted element, so the
  // previous channel's last element keeps its own parameters even while the
  // next channel's parameters are being loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bn_data_1 <= '0;
      bn_data_2 <= '0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
    end else if (advance) begin
      s1_valid <= accept;
      s1_last  <= accept && elem_last && ch_last;
      if (accept) begin
        bn_data_1 <= d1_next;
        bn_data_2 <= d2_next;
      end
    end
  end

  // Stage 2: capture the datapath result untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (advance) begin
      out_valid <= s1_valid;
      out_last  <= s1_last;
      if (s1_valid) begin
        out_data <= bn_result;
      end
    end
  end

endmodule
